// File: rtl/checkbit_pkg.sv
// Shared types, checkpoint code constants and decode helpers for the
// management-GPIO checkbit monitor.
package checkbit_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_DONE    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_START,
      EV_FAIL,
      EV_PASS
   } ev_kind_t;

   localparam logic [7:0] START_PREFIX  = 8'hA0;
   localparam logic [7:0] RESULT_PREFIX = 8'hAB;
   localparam logic [3:0] START_SUFFIX  = 4'h0;
   localparam logic [3:0] FAIL_SUFFIX   = 4'h0;
   localparam logic [3:0] PASS_SUFFIX   = 4'h1;

   localparam logic [3:0] TEST_BYTE  = 4'h1;
   localparam logic [3:0] TEST_SHORT = 4'h2;
   localparam logic [3:0] TEST_WORD  = 4'h4;

   localparam logic [2:0] MASK_BYTE  = 3'b001;
   localparam logic [2:0] MASK_SHORT = 3'b010;
   localparam logic [2:0] MASK_WORD  = 3'b100;

   // Test nibble to result-mask bit; zero for anything that is not a known test.
   function automatic logic [2:0] test_bit(input logic [3:0] nibble);
      logic [2:0] mask;
      case (nibble)
         TEST_BYTE:  mask = MASK_BYTE;
         TEST_SHORT: mask = MASK_SHORT;
         TEST_WORD:  mask = MASK_WORD;
         default:    mask = 3'b000;
      endcase
      return mask;
   endfunction

   // Classify a 16-bit checkpoint word; unknown prefixes/tests decode to EV_NONE.
   function automatic ev_kind_t classify(input logic [15:0] code);
      ev_kind_t kind;
      kind = EV_NONE;
      if (test_bit(code[7:4]) != 3'b000) begin
         if (code[15:8] == START_PREFIX && code[3:0] == START_SUFFIX) begin
            kind = EV_START;
         end else if (code[15:8] == RESULT_PREFIX && code[3:0] == FAIL_SUFFIX) begin
            kind = EV_FAIL;
         end else if (code[15:8] == RESULT_PREFIX && code[3:0] == PASS_SUFFIX) begin
            kind = EV_PASS;
         end
      end
      return kind;
   endfunction

endpackage

// File: rtl/checkbit_monitor_if.sv
// Checkpoint input and monitor result bundle. The master side drives the
// GPIO checkpoint word and clear; the monitor (slave) drives the results.
interface checkbit_monitor_if;

   logic [15:0] checkbits;
   logic        clear;
   logic        event_valid;
   logic [15:0] event_code;
   logic [2:0]  state;
   logic [2:0]  pass_mask;
   logic [2:0]  fail_mask;
   logic        done;
   logic        failed;
   logic        timeout;

   modport master (
      output checkbits, clear,
      input  event_valid, event_code, state, pass_mask, fail_mask, done, failed, timeout
   );

   modport slave (
      input  checkbits, clear,
      output event_valid, event_code, state, pass_mask, fail_mask, done, failed, timeout
   );

endinterface

// File: rtl/checkbit_filter.sv
// Synchronizes the asynchronous checkpoint word and accepts a value only after
// it has been seen unchanged for STABLE_CYCLES synchronized samples.
module checkbit_filter #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic [15:0] checkbits,
   output logic        event_valid,
   output logic [15:0] event_code
);

   localparam logic [7:0] ACCEPT_COUNT = 8'(STABLE_CYCLES - 1);

   logic [15:0] sync_meta;
   logic [15:0] sync_out;
   logic [15:0] candidate;
   logic [7:0]  run_count;
   logic        accept;

   // A repeat of the last accepted value is not a new event.
   assign accept = (run_count == ACCEPT_COUNT) && (candidate != event_code);

   // Two-flop synchronizer; clear deliberately leaves it alone so the pin
   // value is not lost across a clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_meta <= '0;
         sync_out  <= '0;
      end else begin
         sync_meta <= checkbits;
         sync_out  <= sync_meta;
      end
   end

   // Candidate/run-counter stability filter and registered acceptance pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         candidate   <= '0;
         run_count   <= '0;
         event_valid <= 1'b0;
         event_code  <= '0;
      end else if (clear) begin
         candidate   <= '0;
         run_count   <= '0;
         event_valid <= 1'b0;
         event_code  <= '0;
      end else begin
         event_valid <= accept;
         if (accept) begin
            event_code <= candidate;
         end
         if (sync_out != candidate) begin
            candidate <= sync_out;
            run_count <= '0;
         end else if (run_count != 8'hFF) begin
            run_count <= run_count + 8'd1;
         end
      end
   end

endmodule

// File: rtl/checkbit_monitor.sv
// Firmware checkpoint monitor: decodes accepted checkbit words into a
// test-sequence FSM with per-test pass/fail masks and a global timeout.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | waiting for the first start code
//   ST_RUN     | a test is latched; pass/fail codes are checked
//   ST_DONE    | byte test passed, whole sequence complete (terminal)
//   ST_FAIL    | fail or out-of-sequence result seen (terminal)
//   ST_TIMEOUT | no terminal state within TIMEOUT_CYCLES (terminal)
module checkbit_monitor
   import checkbit_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input logic               clock,
   input logic               reset,
   checkbit_monitor_if.slave bus
);

   localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  T_LIMIT = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  T_LAST  = TW'(TIMEOUT_CYCLES - 1);

   state_t        state_q, state_n;
   logic [2:0]    cur_q, cur_n;
   logic [2:0]    pass_q, pass_n;
   logic [2:0]    fail_q, fail_n;
   logic [TW-1:0] tcnt_q;
   logic          done_q, failed_q, timeout_q;
   logic          active;
   logic          ev_valid;
   logic [15:0]   ev_code;
   ev_kind_t      ev_kind;
   logic [2:0]    ev_bit;

   checkbit_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .clock       (clock),
      .reset       (reset),
      .clear       (bus.clear),
      .checkbits   (bus.checkbits),
      .event_valid (ev_valid),
      .event_code  (ev_code)
   );

   assign active  = (state_q == ST_IDLE) || (state_q == ST_RUN);
   assign ev_kind = ev_valid ? classify(ev_code) : EV_NONE;
   assign ev_bit  = test_bit(ev_code[7:4]);

   // Next-state and mask update; the timeout only wins if the event in the
   // same cycle left the sequence non-terminal.
   always_comb begin
      state_n = state_q;
      cur_n   = cur_q;
      pass_n  = pass_q;
      fail_n  = fail_q;
      case (state_q)
         ST_IDLE: begin
            case (ev_kind)
               EV_START: begin
                  state_n = ST_RUN;
                  cur_n   = ev_bit;
               end
               EV_FAIL, EV_PASS: begin
                  fail_n  = fail_q | ev_bit;
                  state_n = ST_FAIL;
               end
               default: ;
            endcase
         end
         ST_RUN: begin
            case (ev_kind)
               EV_START: cur_n = ev_bit;
               EV_FAIL: begin
                  fail_n  = fail_q | ev_bit;
                  state_n = ST_FAIL;
               end
               EV_PASS: begin
                  if (ev_bit == cur_q) begin
                     pass_n = pass_q | ev_bit;
                     if (ev_bit == MASK_BYTE) begin
                        state_n = ST_DONE;
                     end
                  end else begin
                     fail_n  = fail_q | ev_bit;
                     state_n = ST_FAIL;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
      if (active && (tcnt_q >= T_LAST) &&
          (state_n == ST_IDLE || state_n == ST_RUN)) begin
         state_n = ST_TIMEOUT;
      end
   end

   // State, masks and registered status flags; clear overrides any event.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cur_q     <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         done_q    <= 1'b0;
         failed_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else if (bus.clear) begin
         state_q   <= ST_IDLE;
         cur_q     <= '0;
         pass_q    <= '0;
         fail_q    <= '0;
         done_q    <= 1'b0;
         failed_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_n;
         cur_q     <= cur_n;
         pass_q    <= pass_n;
         fail_q    <= fail_n;
         done_q    <= (state_n == ST_DONE);
         failed_q  <= (state_n == ST_FAIL);
         timeout_q <= (state_n == ST_TIMEOUT);
      end
   end

   // Saturating cycle counter, running only while the sequence is live.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tcnt_q <= '0;
      end else if (bus.clear) begin
         tcnt_q <= '0;
      end else if (active && tcnt_q != T_LIMIT) begin
         tcnt_q <= tcnt_q + TW'(1);
      end
   end

   assign bus.event_valid = ev_valid;
   assign bus.event_code  = ev_code;
   assign bus.state       = state_q;
   assign bus.pass_mask   = pass_q;
   assign bus.fail_mask   = fail_q;
   assign bus.done        = done_q;
   assign bus.failed      = failed_q;
   assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_checkbit_monitor.sv
// Scoreboard bench: stimulus pushes the expected event (code plus resulting
// state/masks) before driving it; a negedge monitor pops on every event_valid
// and checks the code, then the state/masks one cycle later.
module tb_checkbit_monitor;

   logic clock = 1'b0;
   logic rst_a;
   logic rst_t;

   always #5 clock = ~clock;

   checkbit_monitor_if bus_a ();
   checkbit_monitor_if bus_t ();

   checkbit_monitor #(.STABLE_CYCLES(4)) dut_a (
      .clock (clock),
      .reset (rst_a),
      .bus   (bus_a)
   );

   checkbit_monitor #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut_t (
      .clock (clock),
      .reset (rst_t),
      .bus   (bus_t)
   );

   typedef struct {
      logic [15:0] code;
      logic [2:0]  st;
      logic [2:0]  pm;
      logic [2:0]  fm;
   } exp_t;

   exp_t sb_q[$];
   exp_t pend;
   logic pend_on = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   ev_seen_a = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [15:0] c, input logic [2:0] st, input logic [2:0] pm,
                       input logic [2:0] fm);
      exp_t e;
      e.code = c;
      e.st   = st;
      e.pm   = pm;
      e.fm   = fm;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor.
   always @(negedge clock) begin
      if (pend_on) begin
         check("post_state", 32'(bus_a.state), 32'(pend.st));
         check("post_pass_mask", 32'(bus_a.pass_mask), 32'(pend.pm));
         check("post_fail_mask", 32'(bus_a.fail_mask), 32'(pend.fm));
         check("post_done", 32'(bus_a.done), 32'(pend.st == 3'd2));
         check("post_failed", 32'(bus_a.failed), 32'(pend.st == 3'd3));
         check("post_timeout", 32'(bus_a.timeout), 32'(pend.st == 3'd4));
         pend_on = 1'b0;
      end
      if (bus_a.event_valid === 1'b1) begin
         ev_seen_a++;
         if (sb_q.size() == 0) begin
            check("unexpected_event", {16'h0, bus_a.event_code}, 32'hDEAD_0000);
         end else begin
            pend = sb_q.pop_front();
            check("event_code", 32'(bus_a.event_code), 32'(pend.code));
            pend_on = 1'b1;
         end
      end
   end

   task automatic hold_a(input logic [15:0] v, input int n);
      @(negedge clock);
      bus_a.checkbits = v;
      repeat (n) @(posedge clock);
   endtask

   task automatic reset_a();
      @(negedge clock);
      bus_a.checkbits = 16'h0000;
      bus_a.clear     = 1'b0;
      rst_a           = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      rst_a = 1'b0;
   endtask

   // Counts edges after the sampling edge until event_valid is seen.
   task automatic measure_a(output int n);
      @(posedge clock);
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (bus_a.event_valid !== 1'b1 && n < 40);
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, "_state"}, 32'(bus_a.state), 32'd0);
      check({tag, "_pass_mask"}, 32'(bus_a.pass_mask), 32'd0);
      check({tag, "_fail_mask"}, 32'(bus_a.fail_mask), 32'd0);
      check({tag, "_event_code"}, 32'(bus_a.event_code), 32'h0);
      check({tag, "_event_valid"}, 32'(bus_a.event_valid), 32'd0);
      check({tag, "_flags"}, 32'({bus_a.done, bus_a.failed, bus_a.timeout}), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n;
      rst_a = 1'b1;
      rst_t = 1'b1;
      bus_a.checkbits = 16'h0;
      bus_a.clear     = 1'b0;
      bus_t.checkbits = 16'h0;
      bus_t.clear     = 1'b0;
      repeat (2) @(negedge clock);
      check_idle_a("reset");
      check("reset_t_state", 32'(bus_t.state), 32'd0);

      // Full passing sequence word/short/byte.
      reset_a();
      base = ev_seen_a;
      push(16'hA040, 3'd1, 3'b000, 3'b000); hold_a(16'hA040, 20);
      push(16'hAB41, 3'd1, 3'b100, 3'b000); hold_a(16'hAB41, 20);
      push(16'hA020, 3'd1, 3'b100, 3'b000); hold_a(16'hA020, 20);
      push(16'hAB21, 3'd1, 3'b110, 3'b000); hold_a(16'hAB21, 20);
      push(16'hA010, 3'd1, 3'b110, 3'b000); hold_a(16'hA010, 20);
      push(16'hAB11, 3'd2, 3'b111, 3'b000); hold_a(16'hAB11, 20);
      check("seq_event_count", 32'(ev_seen_a - base), 32'd6);
      check("seq_done", 32'(bus_a.done), 32'd1);
      check("seq_pass_mask", 32'(bus_a.pass_mask), 32'h7);

      // Fail code, then a late pass that must not change anything.
      reset_a();
      push(16'hA040, 3'd1, 3'b000, 3'b000); hold_a(16'hA040, 20);
      push(16'hAB40, 3'd3, 3'b000, 3'b100); hold_a(16'hAB40, 20);
      push(16'hAB41, 3'd3, 3'b000, 3'b100); hold_a(16'hAB41, 20);
      check("fail_failed", 32'(bus_a.failed), 32'd1);
      check("fail_mask_word", 32'(bus_a.fail_mask), 32'h4);
      push(16'h0000, 3'd3, 3'b000, 3'b100); hold_a(16'h0000, 20);

      // Clear from a terminal state.
      @(negedge clock); bus_a.clear = 1'b1;
      @(negedge clock); bus_a.clear = 1'b0;
      check_idle_a("clear");

      // Clear coinciding with an event: event pulses, decode discarded, then
      // the still-present value re-qualifies.
      push(16'hA040, 3'd0, 3'b000, 3'b000);
      @(negedge clock); bus_a.checkbits = 16'hA040;
      n = 0;
      while (bus_a.event_valid !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      check("clear_event_seen", 32'(n < 40), 32'd1);
      bus_a.clear = 1'b1;
      @(negedge clock); bus_a.clear = 1'b0;
      push(16'hA040, 3'd1, 3'b000, 3'b000);
      repeat (20) @(posedge clock);
      #1 check("clear_requal_state", 32'(bus_a.state), 32'd1);

      // Latency and glitch rejection.
      reset_a();
      push(16'hA040, 3'd1, 3'b000, 3'b000);
      @(negedge clock); bus_a.checkbits = 16'hA040;
      measure_a(n);
      check("latency_edges", 32'(n), 32'd6);
      repeat (15) @(posedge clock);
      base = ev_seen_a;
      hold_a(16'hAB40, 2); hold_a(16'hA040, 20);
      hold_a(16'hAB40, 3); hold_a(16'hA040, 20);
      check("glitch_no_event", 32'(ev_seen_a - base), 32'd0);
      check("glitch_state_run", 32'(bus_a.state), 32'd1);
      push(16'hAB40, 3'd3, 3'b000, 3'b100); hold_a(16'hAB40, 4);
      push(16'hA040, 3'd3, 3'b000, 3'b100); hold_a(16'hA040, 20);
      check("stable4_events", 32'(ev_seen_a - base), 32'd2);

      // Sequence error: pass for a test other than the latched one.
      reset_a();
      push(16'hA020, 3'd1, 3'b000, 3'b000); hold_a(16'hA020, 20);
      push(16'hAB41, 3'd3, 3'b000, 3'b100); hold_a(16'hAB41, 20);
      check("seqerr_failed", 32'(bus_a.failed), 32'd1);
      check("seqerr_fail_mask", 32'(bus_a.fail_mask), 32'h4);

      // Asynchronous reset mid-RUN, then full re-qualification.
      reset_a();
      push(16'hA040, 3'd1, 3'b000, 3'b000); hold_a(16'hA040, 20);
      push(16'hAB41, 3'd1, 3'b100, 3'b000); hold_a(16'hAB41, 20);
      hold_a(16'hA040, 2);
      @(negedge clock);
      #2 rst_a = 1'b1;
      #1 check_idle_a("async_reset");
      repeat (2) @(posedge clock);
      @(negedge clock); rst_a = 1'b0;
      push(16'hA040, 3'd1, 3'b000, 3'b000);
      measure_a(n);
      check("requal_latency", 32'(n), 32'd6);
      repeat (10) @(posedge clock);

      // Timeout with only a start code.
      @(negedge clock); rst_t = 1'b1; bus_t.checkbits = 16'h0;
      repeat (2) @(posedge clock);
      @(negedge clock); rst_t = 1'b0; bus_t.checkbits = 16'hA040;
      repeat (99) @(posedge clock);
      #1;
      check("to_before_state", 32'(bus_t.state), 32'd1);
      check("to_before_flag", 32'(bus_t.timeout), 32'd0);
      @(posedge clock);
      #1;
      check("to_flag", 32'(bus_t.timeout), 32'd1);
      check("to_state", 32'(bus_t.state), 32'd4);
      check("to_other_flags", 32'({bus_t.done, bus_t.failed}), 32'd0);

      // Fail event processed in the same cycle the timeout would fire.
      @(negedge clock); rst_t = 1'b1; bus_t.checkbits = 16'h0;
      repeat (2) @(posedge clock);
      @(negedge clock); rst_t = 1'b0; bus_t.checkbits = 16'hA040;
      repeat (92) @(posedge clock);
      @(negedge clock); bus_t.checkbits = 16'hAB40;
      repeat (7) @(posedge clock);
      #1;
      check("tie_event_valid", 32'(bus_t.event_valid), 32'd1);
      check("tie_event_code", 32'(bus_t.event_code), 32'hAB40);
      @(posedge clock);
      #1;
      check("tie_failed", 32'(bus_t.failed), 32'd1);
      check("tie_timeout", 32'(bus_t.timeout), 32'd0);
      check("tie_fail_mask", 32'(bus_t.fail_mask), 32'h4);
      repeat (5) @(posedge clock);
      #1 check("tie_hold_state", 32'(bus_t.state), 32'd3);

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
